bram_stream_ctrl: RTL and testbench



---
 rtl/bram_stream_ctrl.sv | 146 ++++++++++++++
 tb/tb_bram_stream_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_ctrl.sv
// Frame buffer between a valid/ready input stream and a single-port block RAM:
// fills 2^ADDR_W words, then plays them back with read latency hidden by a small FIFO.
module bram_stream_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned REVERSE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              frame_done,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam int unsigned FRAME_LEN = 1 << ADDR_W;
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned FIFO_D    = RD_LAT + 1;
  localparam int unsigned PTR_W     = 2;
  localparam int unsigned SLOTS     = 1 << PTR_W;
  localparam int unsigned OCC_W     = 3;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]    issued_q;
  logic [CNT_W-1:0]    out_q;
  logic [RD_LAT-1:0]   pipe_q;
  logic [DATA_W-1:0]   fifo_mem [SLOTS];
  logic [PTR_W-1:0]    rd_idx_q, wr_idx_q;
  logic [PTR_W-1:0]    fifo_cnt_q;

  logic                rd_issue;
  logic                ret;
  logic                fifo_empty;
  logic                out_hs;
  logic                push;
  logic                pop;
  logic [OCC_W-1:0]    occ;
  logic [ADDR_W-1:0]   rd_addr;

  // Reads in flight plus buffered words; bounded by the FIFO depth so pushes never overflow.
  always_comb begin
    occ = OCC_W'(fifo_cnt_q);
    for (int i = 0; i < RD_LAT; i++) begin
      occ = occ + OCC_W'(pipe_q[i]);
    end
  end

  assign rd_addr = (REVERSE != 0) ? ~issued_q[ADDR_W-1:0] : issued_q[ADDR_W-1:0];
  assign ret        = pipe_q[RD_LAT-1];
  assign fifo_empty = (fifo_cnt_q == '0);

  // Next state and all handshake / RAM port decode; a returning word bypasses an empty FIFO.
  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_din   = s_data;
    rd_issue   = 1'b0;
    frame_done = 1'b0;
    m_valid    = 1'b0;
    m_data     = fifo_empty ? bram_dout : fifo_mem[rd_idx_q];
    out_hs     = 1'b0;
    if (!rst) begin
      m_valid = ~fifo_empty | ret;
      out_hs  = m_valid & m_ready;
      case (state_q)
        FILL: begin
          s_ready = 1'b1;
          if (s_valid) begin
            bram_we   = 1'b1;
            bram_addr = wr_ptr_q;
            if (wr_ptr_q == {ADDR_W{1'b1}}) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((issued_q < CNT_W'(FRAME_LEN)) && (occ < OCC_W'(FIFO_D))) begin
            rd_issue  = 1'b1;
            bram_addr = rd_addr;
          end
          if (out_hs && (out_q == CNT_W'(FRAME_LEN - 1))) begin
            frame_done = 1'b1;
            state_d    = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  assign push = ret & ~(fifo_empty & m_ready);
  assign pop  = out_hs & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      issued_q   <= '0;
      out_q      <= '0;
      pipe_q     <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (bram_we) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      pipe_q <= RD_LAT'({pipe_q, rd_issue});
      if (frame_done) begin
        issued_q <= '0;
        out_q    <= '0;
      end else begin
        if (rd_issue) issued_q <= issued_q + CNT_W'(1);
        if (out_hs)   out_q    <= out_q + CNT_W'(1);
      end
      if (push) wr_idx_q <= wr_idx_q + PTR_W'(1);
      if (pop)  rd_idx_q <= rd_idx_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_q + PTR_W'(push) - PTR_W'(pop);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_idx_q] <= bram_dout;
    end
  end

endmodule

// File: tb/tb_bram_stream_ctrl.sv
// Scoreboard bench: two instances (RD_LAT=1 ascending, RD_LAT=2 descending), each
// with its own RAM model, random gaps/backpressure, mid-frame reset and back-to-back frames.
module tb_bram_stream_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned FL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit lane_done [2];
  int lane_frames [2];
  int lane_left [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int ln, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d t=%0t: got 0x%0h expected 0x%0h", nm, ln, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned RL  = (g == 0) ? 1 : 2;
    localparam int unsigned REV = g;

    logic          rst, s_valid, s_ready, m_valid, m_ready, frame_done, bram_we;
    logic [DW-1:0] s_data, m_data, bram_din, bram_dout;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] mem [FL];
    logic [DW-1:0] rd1;

    bram_stream_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL), .REVERSE(REV)) u_dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .frame_done(frame_done),
      .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
    );

    // Single-port RAM model with RL cycles of read latency.
    always @(posedge clk) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      rd1 <= mem[bram_addr];
    end
    if (RL == 1) begin : g_l1
      assign bram_dout = rd1;
    end else begin : g_l2
      logic [DW-1:0] rd2;
      always @(posedge clk) rd2 <= rd1;
      assign bram_dout = rd2;
    end

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] in_buf [$];
    logic [DW-1:0] held_data;
    int outn = 0, frames = 0, last_in_cyc = 0, rmode = 0;
    bit draining = 0, first_seen = 0, held = 0, was_rst = 0;

    // Monitor: builds each expected frame from accepted inputs, checks outputs against it.
    always @(negedge clk) begin
      if (rst) begin
        chk("rst_s_ready", g, s_ready, 0);
        chk("rst_m_valid", g, m_valid, 0);
        chk("rst_bram_we", g, bram_we, 0);
        chk("rst_bram_addr", g, bram_addr, 0);
        chk("rst_frame_done", g, frame_done, 0);
        exp_q.delete();
        in_buf.delete();
        outn = 0; draining = 0; first_seen = 0; held = 0; was_rst = 1;
      end else begin
        if (was_rst) begin
          chk("post_rst_m_valid", g, m_valid, 0);
          was_rst = 0;
        end
        chk("s_ready", g, s_ready, !draining);
        chk("bram_we", g, bram_we, s_valid && !draining);
        if (!draining) chk("idle_m_valid", g, m_valid, 0);
        if (s_valid && s_ready) begin
          chk("wr_addr", g, bram_addr, in_buf.size());
          chk("wr_din", g, bram_din, s_data);
          in_buf.push_back(s_data);
          if (in_buf.size() == FL) begin
            for (int i = 0; i < FL; i++) exp_q.push_back((REV != 0) ? in_buf[FL-1-i] : in_buf[i]);
            in_buf.delete();
            draining = 1; first_seen = 0; last_in_cyc = cyc;
          end
        end
        if (held) begin
          chk("hold_valid", g, m_valid, 1);
          chk("hold_data", g, m_data, held_data);
        end
        if (m_valid && draining && !first_seen) begin
          first_seen = 1;
          chk("first_latency", g, cyc - last_in_cyc, RL + 1);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) chk("out_underflow", g, 1, 0);
          else chk("m_data", g, m_data, exp_q.pop_front());
          chk("frame_done", g, frame_done, outn == FL - 1);
          outn++;
          if (outn == FL) begin
            outn = 0; frames++; draining = 0;
          end
        end else begin
          chk("frame_done_idle", g, frame_done, 0);
        end
        held = m_valid && !m_ready;
        held_data = m_data;
      end
    end

    always @(posedge clk) begin
      #1;
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = !m_ready;
        2: m_ready = 1'b0;
        default: m_ready = 1'($urandom % 2);
      endcase
    end

    task automatic send(input logic [DW-1:0] base, input int n, input bit rnd);
      bit acc;
      int t;
      for (int i = 0; i < n; i++) begin
        acc = 0;
        t = 0;
        s_data = base + DW'(i);
        while (!acc) begin
          s_valid = rnd ? 1'($urandom % 2) : 1'b1;
          @(negedge clk);
          acc = s_valid && s_ready;
          @(posedge clk);
          #1;
          t++;
          if (t > 400) begin
            chk("send_timeout", g, 1, 0);
            acc = 1;
          end
        end
      end
      s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
      int t;
      t = 0;
      while (frames < target && t < 600) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk("frames_reached", g, frames >= target, 1);
    endtask

    initial begin
      int t;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; rmode = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      send(16'h1000, 16, 0);
      wait_frames(1);
      // Gapped input, toggling backpressure, then a long stall mid-frame.
      rmode = 1;
      send(16'h2000, 16, 1);
      t = 0;
      while (!(draining && outn >= 3) && t < 300) begin @(posedge clk); #1; t++; end
      rmode = 2;
      repeat (10) @(posedge clk);
      #1 rmode = 1;
      wait_frames(2);
      rmode = 0;
      // Abandon a frame after 7 outputs, then play a fresh one.
      send(16'hC000, 16, 0);
      t = 0;
      while (outn < 7 && t < 300) begin @(posedge clk); #1; t++; end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      send(16'hA0A0, 16, 0);
      wait_frames(3);
      send(16'h3000, 48, 0);
      wait_frames(6);
      rmode = 3;
      send(16'h5000, 32, 1);
      wait_frames(8);
      lane_frames[g] = frames;
      lane_left[g]   = exp_q.size();
      lane_done[g]   = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(lane_done[0] && lane_done[1]) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("lanes_finished", 0, lane_done[0] && lane_done[1], 1);
    for (int l = 0; l < 2; l++) begin
      chk("frames_total", l, lane_frames[l], 8);
      chk("leftover_words", l, lane_left[l], 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
